iter_branch_comp: RTL and testbench

//  Multi-cycle, parametrised successor to the single-cycle comparator, used by the branch unit.

---
 rtl/iter_branch_comp.sv | 149 ++++++++++++++
 tb/tb_iter_branch_comp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_branch_comp.sv
// rtl/iter_branch_comp.sv - multi-cycle chunked subtractor resolving RISC-V branch conditions
module iter_branch_comp #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [2:0]       funct3,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero,
    output logic             cout,
    output logic             sign,
    output logic             ovf,
    output logic             taken,
    output logic             illegal
);

    localparam int NCHUNK = WIDTH / ((CHUNK < 1) ? 1 : CHUNK);
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || (WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0) begin : g_bad_param
            $error("iter_branch_comp: CHUNK must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       f3_q;
    logic             a_msb_q, b_msb_q;
    logic             carry_q, zacc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic             zero_q, cout_q, sign_q, ovf_q, taken_q, illegal_q;

    logic [CHUNK:0]   sum_d;
    logic [CHUNK-1:0] diff_d;
    logic             carry_d, zero_d, sign_d, ovf_d, lt_d, taken_d, illegal_d;

    // Operands are shifted right each CALC cycle so the low CHUNK bits are always the active chunk
    always_comb begin
        sum_d     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, ~b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        diff_d    = sum_d[CHUNK-1:0];
        carry_d   = sum_d[CHUNK];
        zero_d    = zacc_q & (diff_d == '0);
        sign_d    = diff_d[CHUNK-1];
        ovf_d     = (a_msb_q != b_msb_q) && (sign_d != a_msb_q);
        lt_d      = sign_d ^ ovf_d;
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        case (f3_q)
            3'b000:  taken_d = zero_d;
            3'b001:  taken_d = !zero_d;
            3'b100:  taken_d = lt_d;
            3'b101:  taken_d = !lt_d;
            3'b110:  taken_d = !carry_d;
            3'b111:  taken_d = carry_d;
            default: illegal_d = 1'b1;
        endcase
    end

    // Control FSM; flags are captured only on the final chunk and held until the next result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            f3_q        <= 3'b000;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= data1;
                        b_q     <= data2;
                        f3_q    <= funct3;
                        a_msb_q <= data1[WIDTH-1];
                        b_msb_q <= data2[WIDTH-1];
                        carry_q <= 1'b1;
                        zacc_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= carry_d;
                    zacc_q  <= zacc_q & (diff_d == '0);
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        zero_q      <= zero_d;
                        cout_q      <= carry_d;
                        sign_q      <= sign_d;
                        ovf_q       <= ovf_d;
                        taken_q     <= taken_d;
                        illegal_q   <= illegal_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign sign      = sign_q;
    assign ovf       = ovf_q;
    assign taken     = taken_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_iter_branch_comp.sv
// tb/tb_iter_branch_comp.sv - scoreboard bench running CHUNK=8, 32 and 1 instances in lockstep
module tb_iter_branch_comp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] data1 = '0;
    logic [31:0] data2 = '0;
    logic [2:0]  funct3 = '0;

    wire  [2:0]  in_ready_w;
    wire  [2:0]  out_valid_w;
    wire  [5:0]  flags_w [3];

    logic [5:0]  sb [3][$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            localparam int C = (g == 0) ? 8 : ((g == 1) ? 32 : 1);
            iter_branch_comp #(.WIDTH(32), .CHUNK(C)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready_w[g]),
                .data1     (data1),
                .data2     (data2),
                .funct3    (funct3),
                .flush     (flush),
                .out_valid (out_valid_w[g]),
                .out_ready (out_ready),
                .zero      (flags_w[g][5]),
                .cout      (flags_w[g][4]),
                .sign      (flags_w[g][3]),
                .ovf       (flags_w[g][2]),
                .taken     (flags_w[g][1]),
                .illegal   (flags_w[g][0])
            );
        end
    endgenerate

    function automatic int nch(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 32);
    endfunction

    // Reference: {zero, cout, sign, ovf, taken, illegal} from direct comparisons
    function automatic logic [5:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic [32:0] s;
        longint      r;
        logic        z, c, sg, o, lt, ltu, tk, il;
        s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
        z   = (a == b);
        c   = s[32];
        sg  = s[31];
        r   = longint'($signed(a)) - longint'($signed(b));
        o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        lt  = $signed(a) < $signed(b);
        ltu = a < b;
        il  = 1'b0;
        case (f)
            3'b000:  tk = z;
            3'b001:  tk = !z;
            3'b100:  tk = lt;
            3'b101:  tk = !lt;
            3'b110:  tk = ltu;
            3'b111:  tk = !ltu;
            default: begin tk = 1'b0; il = 1'b1; end
        endcase
        return {z, c, sg, o, tk, il};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pop and compare whenever a result is handed over
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (out_valid_w[i] && out_ready && !rst) begin
                check($sformatf("sb_nonempty%0d", i), 32'(sb[i].size() != 0), 32'd1);
                if (sb[i].size() != 0)
                    check($sformatf("flags_chunk%0d", i), 32'(flags_w[i]), 32'(sb[i].pop_front()));
            end
        end
    end

    task automatic clear_sb();
        for (int i = 0; i < 3; i++) sb[i].delete();
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        check("in_ready_pre", 32'(in_ready_w), 32'h7);
        data1    = a;
        data2    = b;
        funct3   = f;
        in_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) sb[i].push_back(model(a, b, f));
        #1;
        in_valid = 1'b0;
        data1    = $urandom;
        data2    = $urandom;
        funct3   = 3'($urandom);
    endtask

    task automatic wait_done();
        int lat [3];
        for (int i = 0; i < 3; i++) lat[i] = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++)
                if (out_valid_w[i] && lat[i] == 0) lat[i] = n;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && (!out_ready || in_ready_w == 3'h7))
                break;
        end
        for (int i = 0; i < 3; i++) check($sformatf("latency%0d", i), 32'(lat[i]), 32'(nch(i)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  snap [3];
        logic [31:0] ra, rb;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready_w), 32'h7);
        check("rst_out_valid", 32'(out_valid_w), 32'h0);
        for (int i = 0; i < 3; i++) check("rst_flags", 32'(flags_w[i]), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(32'd1, 32'd1, 3'b000);                 wait_done();
        issue(32'd1, 32'd2, 3'b100);                 wait_done();
        issue(32'd1, 32'd2, 3'b110);                 wait_done();
        issue(32'd1, 32'd2, 3'b101);                 wait_done();
        issue(32'h8000_0000, 32'd1, 3'b100);         wait_done();
        issue(32'h8000_0000, 32'd1, 3'b110);         wait_done();
        issue(32'h8000_0000, 32'd1, 3'b111);         wait_done();
        issue(32'd3, 32'hFFFF_FFFF, 3'b111);         wait_done();
        issue(32'd3, 32'hFFFF_FFFF, 3'b101);         wait_done();
        issue(32'd3, 32'hFFFF_FFFF, 3'b010);         wait_done();
        issue(32'h7FFF_FFFF, 32'h8000_0000, 3'b011); wait_done();
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = (k == 0) ? ra : $urandom;
            issue(ra, rb, 3'($urandom_range(7, 0)));
            wait_done();
        end

        // Stall in DONE: outputs must hold while out_ready is low
        out_ready = 1'b0;
        issue(32'h8000_0000, 32'd1, 3'b100);
        wait_done();
        for (int i = 0; i < 3; i++) snap[i] = flags_w[i];
        for (int i = 0; i < 3; i++) check("stall_snap", 32'(snap[i]), 32'(model(32'h8000_0000, 32'd1, 3'b100)));
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", 32'(out_valid_w), 32'h7);
            check("stall_in_ready", 32'(in_ready_w), 32'h0);
            for (int i = 0; i < 3; i++) check("stall_flags", 32'(flags_w[i]), 32'(snap[i]));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", 32'(in_ready_w), 32'h7);
        check("release_out_valid", 32'(out_valid_w), 32'h0);

        // flush in the second CALC cycle
        out_ready = 1'b0;
        issue(32'd9, 32'd4, 3'b001);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready_w), 32'h7);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("flush_out_valid", 32'(out_valid_w), 32'h0);
        end
        clear_sb();

        // flush together with in_valid in IDLE: not accepted
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_idle_in_ready", 32'(in_ready_w), 32'h7);
        @(posedge clk);
        #1;
        check("flush_idle_out_valid", 32'(out_valid_w), 32'h0);

        // asynchronous reset in the second CALC cycle
        issue(32'd7, 32'd7, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid_w), 32'h0);
        check("arst_in_ready", 32'(in_ready_w), 32'h7);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_sb();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready_w), 32'h7);
        issue(32'd5, 32'd5, 3'b001);
        wait_done();
        issue(32'd1, 32'd1, 3'b000);
        wait_done();

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check("sb_drained", 32'(sb[i].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
